// File: rtl/conv1x1_arb.sv
`default_nettype none
// ============================================================================
// Module      : conv1x1_arb
// Description : Round-robin arbiter and bias-table front-end sharing a single
//               conv1x1 datapath among N_REQ requesters. Issues (x, w, bias)
//               with registered outputs, tracks requester IDs through the
//               datapath latency and returns tagged results.
// Revision    : 1.0 - initial release
// ============================================================================
module conv1x1_arb #(
    parameter int WIDTH  = 16,
    parameter int N_REQ  = 4,
    parameter int ID_W   = $clog2(N_REQ),
    parameter int DP_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*WIDTH-1:0]   req_x,
    input  logic [N_REQ*WIDTH-1:0]   req_w,
    input  logic                     cfg_we,
    input  logic [ID_W-1:0]          cfg_id,
    input  logic [WIDTH-1:0]         cfg_bias,
    output logic                     dp_valid_in,
    output logic [WIDTH-1:0]         dp_x,
    output logic [WIDTH-1:0]         dp_w,
    output logic [WIDTH-1:0]         dp_b,
    input  logic [2*WIDTH-1:0]       dp_y,
    input  logic                     dp_valid_out,
    output logic                     resp_valid,
    output logic [ID_W-1:0]          resp_id,
    output logic [2*WIDTH-1:0]       resp_y,
    output logic                     proto_err
);

    // Round-robin pointer: first index searched on the next arbitration.
    logic [ID_W-1:0]            r_ptr;
    // Per-requester bias table.
    logic [WIDTH-1:0]           r_bias [N_REQ];
    // Tag pipeline; stage DP_LAT lines up with dp_valid_out.
    logic [DP_LAT:0]            r_tag_v;
    logic [DP_LAT:0][ID_W-1:0]  r_tag_id;

    logic                       w_grant_any;
    logic [ID_W-1:0]            w_grant_idx;
    logic [N_REQ-1:0]           w_grant_oh;
    logic [WIDTH-1:0]           w_sel_x;
    logic [WIDTH-1:0]           w_sel_w;
    logic [WIDTH-1:0]           w_sel_b;
    logic [ID_W:0]              w_cand;
    logic                       w_cfg_hit;
    logic [ID_W-1:0]            w_ptr_next;

    // Search upward from the pointer (mod N_REQ) for the first requester.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = {1'b0, r_ptr} + (ID_W+1)'(k);
            if (w_cand >= (ID_W+1)'(N_REQ)) begin
                w_cand = w_cand - (ID_W+1)'(N_REQ);
            end
            if (!w_grant_any && req_valid[w_cand[ID_W-1:0]]) begin
                w_grant_any = 1'b1;
                w_grant_idx = w_cand[ID_W-1:0];
            end
        end
    end

    // Decode the winner to one-hot and mux its operands and bias.
    always_comb begin
        w_grant_oh = '0;
        w_sel_x    = '0;
        w_sel_w    = '0;
        w_sel_b    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant_any && (w_grant_idx == ID_W'(i))) begin
                w_grant_oh[i] = 1'b1;
                w_sel_x       = req_x[i*WIDTH +: WIDTH];
                w_sel_w       = req_w[i*WIDTH +: WIDTH];
                w_sel_b       = r_bias[i];
            end
        end
    end

    // The grant is withheld while reset is held so no requester retires an op.
    assign req_ready  = rst ? '0 : w_grant_oh;
    assign w_cfg_hit  = cfg_we && ({1'b0, cfg_id} < (ID_W+1)'(N_REQ));
    assign w_ptr_next = (w_grant_idx == ID_W'(N_REQ-1)) ? '0 : (w_grant_idx + ID_W'(1));

    // Advance the pointer past the winner; hold it when nobody is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_grant_any) begin
            r_ptr <= w_ptr_next;
        end
    end

    // Bias table writes; out-of-range IDs are dropped. A same-edge grant
    // reads the old entry because the issue mux samples before this update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                r_bias[i] <= '0;
            end
        end else if (w_cfg_hit) begin
            r_bias[cfg_id] <= cfg_bias;
        end
    end

    // Registered issue to the datapath; operands hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_valid_in <= 1'b0;
            dp_x        <= '0;
            dp_w        <= '0;
            dp_b        <= '0;
        end else begin
            dp_valid_in <= w_grant_any;
            if (w_grant_any) begin
                dp_x <= w_sel_x;
                dp_w <= w_sel_w;
                dp_b <= w_sel_b;
            end
        end
    end

    // Shift the requester tag alongside the operation through the datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_v  <= '0;
            r_tag_id <= '0;
        end else begin
            r_tag_v[0]  <= w_grant_any;
            r_tag_id[0] <= w_grant_idx;
            for (int k = 1; k <= DP_LAT; k++) begin
                r_tag_v[k]  <= r_tag_v[k-1];
                r_tag_id[k] <= r_tag_id[k-1];
            end
        end
    end

    // Capture datapath results with the aligned tag; untagged results map to ID 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_y     <= '0;
        end else begin
            resp_valid <= dp_valid_out;
            if (dp_valid_out) begin
                resp_y  <= dp_y;
                resp_id <= r_tag_v[DP_LAT] ? r_tag_id[DP_LAT] : '0;
            end
        end
    end

    // Sticky error when a result and its tag disagree in either direction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else if (dp_valid_out != r_tag_v[DP_LAT]) begin
            proto_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv1x1_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv1x1_arb
// Description : Self-checking bench for conv1x1_arb with a one-cycle
//               datapath model and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv1x1_arb;
    localparam int WIDTH = 16;
    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [N_REQ-1:0]       req_valid = '0;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_x = '0;
    logic [N_REQ*WIDTH-1:0] req_w = '0;
    logic                   cfg_we = 1'b0;
    logic [ID_W-1:0]        cfg_id = '0;
    logic [WIDTH-1:0]       cfg_bias = '0;
    logic                   dp_valid_in;
    logic [WIDTH-1:0]       dp_x, dp_w, dp_b;
    logic [2*WIDTH-1:0]     dp_y;
    logic                   dp_valid_out;
    logic                   resp_valid;
    logic [ID_W-1:0]        resp_id;
    logic [2*WIDTH-1:0]     resp_y;
    logic                   proto_err;
    logic                   inj = 1'b0;
    logic                   dpm_v;
    logic [2*WIDTH-1:0]     dpm_y;

    conv1x1_arb #(.WIDTH(WIDTH), .N_REQ(N_REQ), .ID_W(ID_W), .DP_LAT(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_w(req_w), .cfg_we(cfg_we), .cfg_id(cfg_id),
        .cfg_bias(cfg_bias), .dp_valid_in(dp_valid_in), .dp_x(dp_x),
        .dp_w(dp_w), .dp_b(dp_b), .dp_y(dp_y), .dp_valid_out(dp_valid_out),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_y(resp_y),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    // One-cycle datapath model: y = x*w + b.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dpm_v <= 1'b0;
            dpm_y <= '0;
        end else begin
            dpm_v <= dp_valid_in;
            dpm_y <= 32'(dp_x) * 32'(dp_w) + 32'(dp_b);
        end
    end
    assign dp_valid_out = dpm_v | inj;
    assign dp_y         = dpm_y;

    typedef struct {
        int     due;
        int     id;
        longint y;
        bit     ychk;
    } exp_t;

    exp_t   q[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     m_ptr = 0;
    longint m_bias[N_REQ];
    bit     m_err = 1'b0;
    int     vx[N_REQ];
    int     vw[N_REQ];
    int     g;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: predict grant, advance model, check outputs after the edge.
    task automatic do_cycle(output int gi);
        exp_t e;
        int   c;
        for (int i = 0; i < N_REQ; i++) begin
            req_x[i*WIDTH +: WIDTH] = vx[i][WIDTH-1:0];
            req_w[i*WIDTH +: WIDTH] = vw[i][WIDTH-1:0];
        end
        #1;
        gi = -1;
        for (int k = 0; k < N_REQ; k++) begin
            c = (m_ptr + k) % N_REQ;
            if (gi < 0 && req_valid[c]) gi = c;
        end
        chk("req_ready", 64'(req_ready), (gi < 0) ? 64'd0 : (64'd1 << gi));
        if (gi >= 0) begin
            e.due  = cyc + 3;
            e.id   = gi;
            e.y    = longint'(vx[gi]) * longint'(vw[gi]) + m_bias[gi];
            e.ychk = 1'b1;
            q.push_back(e);
            m_ptr = (gi + 1) % N_REQ;
        end
        if (cfg_we && int'(cfg_id) < N_REQ) m_bias[cfg_id] = longint'(cfg_bias);
        if (inj) begin
            e.due = cyc + 1; e.id = 0; e.y = 0; e.ychk = 1'b0;
            q.push_front(e);
        end
        @(posedge clk);
        cyc++;
        if (inj) m_err = 1'b1;
        #1;
        if (q.size() > 0 && q[0].due == cyc) begin
            chk("resp_valid", 64'(resp_valid), 64'd1);
            chk("resp_id", 64'(resp_id), 64'(q[0].id));
            if (q[0].ychk) chk("resp_y", 64'(resp_y), 64'(q[0].y));
            void'(q.pop_front());
        end else begin
            chk("resp_idle", 64'(resp_valid), 64'd0);
        end
        chk("proto_err", 64'(proto_err), 64'(m_err));
    endtask

    task automatic idle(input int n);
        int gd;
        req_valid = '0;
        cfg_we    = 1'b0;
        for (int k = 0; k < n; k++) do_cycle(gd);
    endtask

    task automatic cfg_write(input int id, input int val);
        int gd;
        req_valid = '0;
        cfg_we = 1'b1; cfg_id = ID_W'(id); cfg_bias = WIDTH'(val);
        do_cycle(gd);
        cfg_we = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_dp_valid_in"}, 64'(dp_valid_in), 64'd0);
        chk({tag, "_dp_xwb"}, {16'd0, dp_x, dp_w, dp_b}, 64'd0);
        chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        chk({tag, "_resp_id"}, 64'(resp_id), 64'd0);
        chk({tag, "_resp_y"}, 64'(resp_y), 64'd0);
        chk({tag, "_proto_err"}, 64'(proto_err), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < N_REQ; i++) begin
            m_bias[i] = 0; vx[i] = 0; vw[i] = 0;
        end
        // Reset state, with requests pending to show ready is suppressed.
        req_valid = '1;
        #12;
        chk_all_zero("reset");
        req_valid = '0;
        #1 rst = 1'b0;

        // Basic: bias[2]=5, x=3, w=4 -> y=17 tagged ID 2.
        cfg_write(2, 5);
        vx[2] = 3; vw[2] = 4; req_valid = 4'b0100;
        do_cycle(g);
        chk("basic_grant", 64'(g), 64'd2);
        idle(4);

        // All four requesters: bias {10,20,30,40}, x=i+1, w=2.
        for (int i = 0; i < N_REQ; i++) cfg_write(i, 10 * (i + 1));
        vx[3] = 1; vw[3] = 1; req_valid = 4'b1000;
        do_cycle(g);
        for (int i = 0; i < N_REQ; i++) begin
            vx[i] = i + 1; vw[i] = 2;
        end
        req_valid = 4'b1111;
        for (int k = 0; k < N_REQ; k++) begin
            do_cycle(g);
            chk("rr_order", 64'(g), 64'(k));
        end
        idle(4);

        // Pointer at 2, only requesters 0 and 3 active: alternate 3,0,3,0.
        vx[1] = 5; vw[1] = 6; req_valid = 4'b0010;
        do_cycle(g);
        req_valid = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            do_cycle(g);
            chk("alt_grant", 64'(g), (k % 2 == 0) ? 64'd3 : 64'd0);
        end
        idle(4);

        // Same-edge bias write and grant: old bias used, new from next grant.
        cfg_write(1, 7);
        vx[1] = 1; vw[1] = 1; req_valid = 4'b0010;
        cfg_we = 1'b1; cfg_id = 2'd1; cfg_bias = 16'd99;
        do_cycle(g);
        cfg_we = 1'b0;
        do_cycle(g);
        idle(4);

        // Randomised traffic with occasional bias writes.
        req_valid = '0;
        for (int n = 0; n < 80; n++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    req_valid[i] = 1'b1;
                    vx[i] = int'($urandom_range(0, 65535));
                    vw[i] = int'($urandom_range(0, 65535));
                end
            end
            cfg_we   = ($urandom_range(0, 3) == 0);
            cfg_id   = ID_W'($urandom_range(0, N_REQ - 1));
            cfg_bias = WIDTH'($urandom_range(0, 65535));
            do_cycle(g);
            if (g >= 0) req_valid[g] = 1'b0;
        end
        idle(4);

        // Spurious dp_valid_out with nothing in flight: sticky error, ID 0.
        inj = 1'b1;
        do_cycle(g);
        inj = 1'b0;
        idle(3);

        // Reset while an operation is in flight: it must vanish.
        vx[2] = 9; vw[2] = 9; req_valid = 4'b0100;
        do_cycle(g);
        req_valid = '0;
        rst = 1'b1;
        #1;
        chk_all_zero("midreset");
        q.delete();
        m_ptr = 0;
        m_err = 1'b0;
        for (int i = 0; i < N_REQ; i++) m_bias[i] = 0;
        @(posedge clk);
        #2 rst = 1'b0;
        idle(4);
        // Pointer back at 0 and bias cleared: all-valid grants 0 first, y=x*w.
        for (int i = 0; i < N_REQ; i++) begin
            vx[i] = i + 2; vw[i] = 3;
        end
        req_valid = 4'b1111;
        do_cycle(g);
        chk("ptr_after_reset", 64'(g), 64'd0);
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
